// File: rtl/bus_master_irq.sv
// Core-side initiator for the shared 8-bit tristate peripheral bus, plus interrupt priority select and ACK.
// Define IRQ_MASK_EN to add a local interrupt mask register at MASK_ADDR.
module bus_master_irq #(
    parameter int         NUM_IRQ   = 2,
    parameter int         RD_WAIT   = 1,
    parameter logic [7:0] IDLE_ADDR = 8'hFF,
    parameter logic [7:0] MASK_ADDR = 8'hE0,
    localparam int        ID_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               REQ,
    input  logic               REQ_WE,
    input  logic [7:0]         REQ_ADDR,
    input  logic [7:0]         REQ_WDATA,
    output logic               BUSY,
    output logic               RD_VALID,
    output logic [7:0]         RD_DATA,
    output logic [7:0]         BUS_ADDR,
    inout  wire  [7:0]         BUS_DATA,
    output logic               BUS_WE,
    input  logic [NUM_IRQ-1:0] BUS_INTERRUPTS_RAISE,
    output logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK,
    output logic               IRQ_PENDING,
    output logic [ID_W-1:0]    IRQ_ID,
    input  logic               IRQ_TAKE
);

    // state | meaning
    // IDLE  | bus parked on IDLE_ADDR, accepting REQ
    // WRITE | one cycle driving addr/data with BUS_WE=1
    // READ  | addr held RD_WAIT+1 cycles, data sampled on the last edge
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam int        CW        = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    // ACK cycle plus the two cycles the responder needs to drop its flag
    localparam logic [1:0] BLANK_LEN = 2'd3;

`ifdef IRQ_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    state_t             state, state_nxt;
    logic [CW-1:0]      wait_cnt, wait_cnt_nxt;
    logic [7:0]         addr_q, wdata_q;
    logic               rd_done;
    logic               rd_valid_q;
    logic [7:0]         rd_data_q;
    logic [7:0]         rd_src;
    logic [7:0]         mask_zx;
    logic               mask_hit;
    logic               bus_drive;
    logic [NUM_IRQ-1:0] mask;

    logic [1:0]         blank_cnt [NUM_IRQ];
    logic [NUM_IRQ-1:0] blank;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_q;
    logic [ID_W-1:0]    irq_id;
    logic               take;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_q     <= IDLE_ADDR;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            rd_valid_q <= rd_done;
            if (state == IDLE && REQ) begin
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
            end
            if (rd_done) begin
                rd_data_q <= rd_src;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rd_done      = 1'b0;
        case (state)
            IDLE: begin
                if (REQ) begin
                    state_nxt    = REQ_WE ? WRITE : READ;
                    wait_cnt_nxt = CW'(RD_WAIT);
                end
            end
            WRITE: state_nxt = IDLE;
            READ: begin
                if (wait_cnt == '0) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mask_hit  = MASK_EN && (addr_q == MASK_ADDR);
    // Mask-register writes stay local: no address, data or strobe on the bus
    assign bus_drive = (state == WRITE) && !mask_hit;

    assign BUSY     = (state != IDLE);
    assign BUS_WE   = bus_drive;
    assign BUS_DATA = bus_drive ? wdata_q : 8'hzz;
    assign BUS_ADDR = (state == READ || bus_drive) ? addr_q : IDLE_ADDR;
    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;

`ifdef IRQ_MASK_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mask <= '1;
        end else if (state == WRITE && mask_hit) begin
            mask <= wdata_q[NUM_IRQ-1:0];
        end
    end
`else
    assign mask = '1;
`endif

    always_comb begin
        mask_zx              = '0;
        mask_zx[NUM_IRQ-1:0] = mask;
        rd_src               = mask_hit ? mask_zx : BUS_DATA;
    end

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            blank[i] = (blank_cnt[i] != 2'd0);
        end
    end

    // Gated by reset so nothing is reported while the block is held in reset
    assign eligible    = BUS_INTERRUPTS_RAISE & ~blank & mask & {NUM_IRQ{RESET}};
    assign IRQ_PENDING = |eligible;
    assign take        = IRQ_TAKE & IRQ_PENDING;

    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_id = ID_W'(i);
            end
        end
    end

    assign IRQ_ID             = irq_id;
    assign BUS_INTERRUPTS_ACK = ack_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ack_q <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                blank_cnt[i] <= 2'd0;
            end
        end else begin
            ack_q <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (take && irq_id == ID_W'(i)) begin
                    ack_q[i]     <= 1'b1;
                    blank_cnt[i] <= BLANK_LEN;
                end else if (blank_cnt[i] != 2'd0) begin
                    blank_cnt[i] <= blank_cnt[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_master_irq.sv
// Self-checking bench for bus_master_irq: registered-decode bus responder, ACK-clearing interrupt
// source model, and scoreboard queues for writes, reads and ACK pulses.
`timescale 1ns/1ps
module tb_bus_master_irq;

    localparam int NUM_IRQ = 2;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               REQ = 1'b0;
    logic               REQ_WE = 1'b0;
    logic [7:0]         REQ_ADDR = 8'hFF;
    logic [7:0]         REQ_WDATA = 8'h00;
    logic               BUSY;
    logic               RD_VALID;
    logic [7:0]         RD_DATA;
    logic [7:0]         BUS_ADDR;
    wire  [7:0]         BUS_DATA;
    logic               BUS_WE;
    logic [NUM_IRQ-1:0] irq_flag;
    logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK;
    logic               IRQ_PENDING;
    logic [0:0]         IRQ_ID;
    logic               IRQ_TAKE = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]         rd_exp_q [$];
    logic [15:0]        wr_exp_q [$];
    logic [NUM_IRQ-1:0] ack_exp_q [$];

    bus_master_irq #(
        .NUM_IRQ   (NUM_IRQ),
        .RD_WAIT   (1),
        .IDLE_ADDR (8'hFF),
        .MASK_ADDR (8'hE0)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .REQ                  (REQ),
        .REQ_WE               (REQ_WE),
        .REQ_ADDR             (REQ_ADDR),
        .REQ_WDATA            (REQ_WDATA),
        .BUSY                 (BUSY),
        .RD_VALID             (RD_VALID),
        .RD_DATA              (RD_DATA),
        .BUS_ADDR             (BUS_ADDR),
        .BUS_DATA             (BUS_DATA),
        .BUS_WE               (BUS_WE),
        .BUS_INTERRUPTS_RAISE (irq_flag),
        .BUS_INTERRUPTS_ACK   (BUS_INTERRUPTS_ACK),
        .IRQ_PENDING          (IRQ_PENDING),
        .IRQ_ID               (IRQ_ID),
        .IRQ_TAKE             (IRQ_TAKE)
    );

    always #5 CLK = ~CLK;

    // Responder at F0..F3 with a registered address decode
    logic [7:0] mem [4];
    logic       resp_en;
    logic [7:0] resp_val;
    assign BUS_DATA = resp_en ? resp_val : 8'hzz;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            resp_en  <= 1'b0;
            resp_val <= 8'h00;
            mem[0]   <= 8'h3C;
            mem[1]   <= 8'h11;
            mem[2]   <= 8'h22;
            mem[3]   <= 8'h33;
        end else begin
            resp_en  <= (BUS_ADDR[7:2] == 6'b111100) && !BUS_WE;
            resp_val <= mem[BUS_ADDR[1:0]];
            if (BUS_WE && BUS_ADDR[7:2] == 6'b111100) begin
                mem[BUS_ADDR[1:0]] <= BUS_DATA;
            end
        end
    end

    // Interrupt sources: flag drops one cycle after the source sees ACK (when auto_clear)
    logic [NUM_IRQ-1:0] irq_set = '0;
    logic [NUM_IRQ-1:0] irq_clr = '0;
    logic [NUM_IRQ-1:0] ack_seen;
    logic               auto_clear = 1'b1;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irq_flag <= '0;
            ack_seen <= '0;
        end else begin
            ack_seen <= BUS_INTERRUPTS_ACK;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (irq_set[i]) begin
                    irq_flag[i] <= 1'b1;
                end else if ((auto_clear && ack_seen[i]) || irq_clr[i]) begin
                    irq_flag[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            checks++;
            if (BUS_WE === 1'b1 && BUSY !== 1'b1) begin
                errors++;
                $display("FAIL we_outside_write: BUS_WE=%b BUSY=%b expected BUSY=1", BUS_WE, BUSY);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic wait_rd_valid(output int lat, output logic [7:0] first_addr, output int we_seen);
        lat        = -1;
        first_addr = 8'h00;
        we_seen    = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            REQ = 1'b0;
            if (c == 1) first_addr = BUS_ADDR;
            if (BUS_WE === 1'b1) we_seen++;
            if (RD_VALID === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUS_ADDR !== 8'hFF || BUS_WE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h we=%b busy=%b expected ff/0/0", BUS_ADDR, BUS_WE, BUSY);
        end
        checks++;
        if (RD_VALID !== 1'b0 || RD_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd: valid=%b data=%h expected 0/00", RD_VALID, RD_DATA);
        end
        checks++;
        if (BUS_INTERRUPTS_ACK !== 2'b00 || IRQ_PENDING !== 1'b0 || IRQ_ID !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: ack=%b pend=%b id=%b expected 00/0/0",
                     BUS_INTERRUPTS_ACK, IRQ_PENDING, IRQ_ID);
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write();
        logic [15:0] exp;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hF1; REQ_WDATA = 8'h05;
        wr_exp_q.push_back({8'hF1, 8'h05});
        @(negedge CLK);
        REQ = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || BUS_WE !== 1'b1) begin
            errors++;
            $display("FAIL write_cycle: busy=%b we=%b expected 1/1", BUSY, BUS_WE);
        end else begin
            exp = wr_exp_q.pop_front();
            checks++;
            if ({BUS_ADDR, BUS_DATA} !== exp) begin
                errors++;
                $display("FAIL write_bus: addr/data=%h expected %h", {BUS_ADDR, BUS_DATA}, exp);
            end
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || BUS_WE !== 1'b0 || BUS_ADDR !== 8'hFF) begin
            errors++;
            $display("FAIL write_after: busy=%b we=%b addr=%h expected 0/0/ff", BUSY, BUS_WE, BUS_ADDR);
        end
    endtask

    task automatic test_read();
        int         lat;
        int         wes;
        logic [7:0] fa;
        logic [7:0] exp;
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        addrs[0] = 8'hF0; datas[0] = 8'h3C;
        addrs[1] = 8'hF1; datas[1] = 8'h05;
        addrs[2] = 8'hF3; datas[2] = 8'h33;
        for (int n = 0; n < 3; n++) begin
            REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = addrs[n];
            rd_exp_q.push_back(datas[n]);
            wait_rd_valid(lat, fa, wes);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL read_latency[%0d]: %0d cycles expected 3", n, lat);
            end
            checks++;
            if (fa !== addrs[n] || wes != 0) begin
                errors++;
                $display("FAIL read_bus[%0d]: addr=%h we_cycles=%0d expected %h/0", n, fa, wes, addrs[n]);
            end
            if (lat > 0) begin
                exp = rd_exp_q.pop_front();
                checks++;
                if (RD_DATA !== exp) begin
                    errors++;
                    $display("FAIL read_data[%0d]: got %h expected %h", n, RD_DATA, exp);
                end
            end
            @(negedge CLK);
            checks++;
            if (RD_VALID !== 1'b0 || RD_DATA !== datas[n]) begin
                errors++;
                $display("FAIL read_hold[%0d]: valid=%b data=%h expected 0/%h", n, RD_VALID, RD_DATA, datas[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          wes;
        logic [7:0]  fa;
        logic [15:0] wexp;
        logic [7:0]  rexp;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hF2; REQ_WDATA = 8'h77;
        wr_exp_q.push_back({8'hF2, 8'h77});
        @(negedge CLK);
        REQ_WE = 1'b0;
        rd_exp_q.push_back(8'h77);
        checks++;
        if (BUS_WE !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write: we=%b expected 1", BUS_WE);
        end else begin
            wexp = wr_exp_q.pop_front();
            checks++;
            if ({BUS_ADDR, BUS_DATA} !== wexp) begin
                errors++;
                $display("FAIL b2b_write_bus: addr/data=%h expected %h", {BUS_ADDR, BUS_DATA}, wexp);
            end
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || BUS_ADDR !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b addr=%h expected 0/ff", BUSY, BUS_ADDR);
        end
        wait_rd_valid(lat, fa, wes);
        checks++;
        if (lat != 3 || fa !== 8'hF2) begin
            errors++;
            $display("FAIL b2b_read: latency=%0d addr=%h expected 3/f2", lat, fa);
        end
        if (lat > 0) begin
            rexp = rd_exp_q.pop_front();
            checks++;
            if (RD_DATA !== rexp) begin
                errors++;
                $display("FAIL b2b_read_data: got %h expected %h", RD_DATA, rexp);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_irq();
        logic [NUM_IRQ-1:0] aexp;
        auto_clear = 1'b1;
        irq_set = 2'b11;
        @(negedge CLK);
        irq_set = 2'b00;
        checks++;
        if (IRQ_PENDING !== 1'b1 || IRQ_ID !== 1'b0 || BUS_INTERRUPTS_ACK !== 2'b00) begin
            errors++;
            $display("FAIL irq_select: pend=%b id=%b ack=%b expected 1/0/00",
                     IRQ_PENDING, IRQ_ID, BUS_INTERRUPTS_ACK);
        end
        IRQ_TAKE = 1'b1;
        ack_exp_q.push_back(2'b01);
        @(negedge CLK);
        IRQ_TAKE = 1'b0;
        aexp = ack_exp_q.pop_front();
        checks++;
        if (BUS_INTERRUPTS_ACK !== aexp) begin
            errors++;
            $display("FAIL irq_ack0: ack=%b expected %b", BUS_INTERRUPTS_ACK, aexp);
        end
        checks++;
        if (IRQ_PENDING !== 1'b1 || IRQ_ID !== 1'b1) begin
            errors++;
            $display("FAIL irq_blank_next: pend=%b id=%b expected 1/1", IRQ_PENDING, IRQ_ID);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (BUS_INTERRUPTS_ACK !== 2'b00 || IRQ_ID !== 1'b1) begin
                errors++;
                $display("FAIL irq_after_ack[%0d]: ack=%b id=%b expected 00/1", c, BUS_INTERRUPTS_ACK, IRQ_ID);
            end
        end
        IRQ_TAKE = 1'b1;
        ack_exp_q.push_back(2'b10);
        @(negedge CLK);
        IRQ_TAKE = 1'b0;
        aexp = ack_exp_q.pop_front();
        checks++;
        if (BUS_INTERRUPTS_ACK !== aexp) begin
            errors++;
            $display("FAIL irq_ack1: ack=%b expected %b", BUS_INTERRUPTS_ACK, aexp);
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (IRQ_PENDING !== 1'b0 || IRQ_ID !== 1'b0) begin
            errors++;
            $display("FAIL irq_drained: pend=%b id=%b expected 0/0", IRQ_PENDING, IRQ_ID);
        end
        IRQ_TAKE = 1'b1;
        @(negedge CLK);
        IRQ_TAKE = 1'b0;
        checks++;
        if (BUS_INTERRUPTS_ACK !== 2'b00) begin
            errors++;
            $display("FAIL irq_take_idle: ack=%b expected 00", BUS_INTERRUPTS_ACK);
        end
    endtask

    task automatic test_blank_window();
        logic [NUM_IRQ-1:0] aexp;
        logic               pend_exp [4];
        pend_exp[0] = 1'b0; pend_exp[1] = 1'b0; pend_exp[2] = 1'b0; pend_exp[3] = 1'b1;
        auto_clear = 1'b0;
        irq_set = 2'b01;
        @(negedge CLK);
        irq_set = 2'b00;
        IRQ_TAKE = 1'b1;
        ack_exp_q.push_back(2'b01);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            IRQ_TAKE = 1'b0;
            if (c == 0) begin
                aexp = ack_exp_q.pop_front();
                checks++;
                if (BUS_INTERRUPTS_ACK !== aexp) begin
                    errors++;
                    $display("FAIL blank_ack: ack=%b expected %b", BUS_INTERRUPTS_ACK, aexp);
                end
            end
            checks++;
            if (IRQ_PENDING !== pend_exp[c]) begin
                errors++;
                $display("FAIL blank_window[%0d]: pend=%b expected %b", c, IRQ_PENDING, pend_exp[c]);
            end
        end
        checks++;
        if (IRQ_ID !== 1'b0) begin
            errors++;
            $display("FAIL blank_represent: id=%b expected 0", IRQ_ID);
        end
        irq_clr = 2'b01;
        @(negedge CLK);
        irq_clr = 2'b00;
        auto_clear = 1'b1;
    endtask

    task automatic test_take_with_write();
        logic [NUM_IRQ-1:0] aexp;
        logic [15:0]        wexp;
        irq_set = 2'b10;
        @(negedge CLK);
        irq_set = 2'b00;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hF3; REQ_WDATA = 8'hA5;
        IRQ_TAKE = 1'b1;
        wr_exp_q.push_back({8'hF3, 8'hA5});
        ack_exp_q.push_back(2'b10);
        @(negedge CLK);
        REQ = 1'b0;
        IRQ_TAKE = 1'b0;
        aexp = ack_exp_q.pop_front();
        checks++;
        if (BUS_INTERRUPTS_ACK !== aexp) begin
            errors++;
            $display("FAIL tw_ack: ack=%b expected %b", BUS_INTERRUPTS_ACK, aexp);
        end
        checks++;
        if (BUS_WE !== 1'b1) begin
            errors++;
            $display("FAIL tw_we: we=%b expected 1", BUS_WE);
        end else begin
            wexp = wr_exp_q.pop_front();
            checks++;
            if ({BUS_ADDR, BUS_DATA} !== wexp) begin
                errors++;
                $display("FAIL tw_bus: addr/data=%h expected %h", {BUS_ADDR, BUS_DATA}, wexp);
            end
        end
        @(negedge CLK);
        checks++;
        if (BUS_INTERRUPTS_ACK !== 2'b00 || BUS_WE !== 1'b0) begin
            errors++;
            $display("FAIL tw_after: ack=%b we=%b expected 00/0", BUS_INTERRUPTS_ACK, BUS_WE);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        int         lat;
        int         wes;
        logic [7:0] fa;
        logic [7:0] exp;
        REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'hF0;
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        REQ = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || BUS_ADDR !== 8'hFF || BUS_WE !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: busy=%b addr=%h we=%b expected 0/ff/0", BUSY, BUS_ADDR, BUS_WE);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (RD_VALID !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_valid[%0d]: valid=%b expected 0", c, RD_VALID);
            end
        end
        RESET = 1'b1;
        @(negedge CLK);
        REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'hF0;
        rd_exp_q.push_back(8'h3C);
        wait_rd_valid(lat, fa, wes);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL abort_fresh_latency: %0d cycles expected 3", lat);
        end
        if (lat > 0) begin
            exp = rd_exp_q.pop_front();
            checks++;
            if (RD_DATA !== exp) begin
                errors++;
                $display("FAIL abort_fresh_data: got %h expected %h", RD_DATA, exp);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_mask();
`ifdef IRQ_MASK_EN
        int                 lat;
        int                 wes;
        logic [7:0]         fa;
        logic [7:0]         rexp;
        logic [NUM_IRQ-1:0] aexp;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hE0; REQ_WDATA = 8'h02;
        @(negedge CLK);
        REQ = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || BUS_WE !== 1'b0) begin
            errors++;
            $display("FAIL mask_write: busy=%b we=%b expected 1/0", BUSY, BUS_WE);
        end
        @(negedge CLK);
        auto_clear = 1'b0;
        irq_set = 2'b11;
        @(negedge CLK);
        irq_set = 2'b00;
        checks++;
        if (IRQ_PENDING !== 1'b1 || IRQ_ID !== 1'b1) begin
            errors++;
            $display("FAIL mask_select: pend=%b id=%b expected 1/1", IRQ_PENDING, IRQ_ID);
        end
        IRQ_TAKE = 1'b1;
        ack_exp_q.push_back(2'b10);
        @(negedge CLK);
        IRQ_TAKE = 1'b0;
        aexp = ack_exp_q.pop_front();
        checks++;
        if (BUS_INTERRUPTS_ACK !== aexp) begin
            errors++;
            $display("FAIL mask_ack: ack=%b expected %b", BUS_INTERRUPTS_ACK, aexp);
        end
        REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'hE0;
        rd_exp_q.push_back(8'h02);
        wait_rd_valid(lat, fa, wes);
        checks++;
        if (lat != 3 || fa !== 8'hE0) begin
            errors++;
            $display("FAIL mask_read_timing: latency=%0d addr=%h expected 3/e0", lat, fa);
        end
        if (lat > 0) begin
            rexp = rd_exp_q.pop_front();
            checks++;
            if (RD_DATA !== rexp) begin
                errors++;
                $display("FAIL mask_read_data: got %h expected %h", RD_DATA, rexp);
            end
        end
        irq_clr = 2'b11;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hE0; REQ_WDATA = 8'h03;
        @(negedge CLK);
        REQ = 1'b0;
        irq_clr = 2'b00;
        auto_clear = 1'b1;
        repeat (2) @(negedge CLK);
`else
        logic [15:0] wexp;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'hE0; REQ_WDATA = 8'h02;
        wr_exp_q.push_back({8'hE0, 8'h02});
        @(negedge CLK);
        REQ = 1'b0;
        checks++;
        if (BUS_WE !== 1'b1) begin
            errors++;
            $display("FAIL nomask_we: we=%b expected 1", BUS_WE);
        end else begin
            wexp = wr_exp_q.pop_front();
            checks++;
            if ({BUS_ADDR, BUS_DATA} !== wexp) begin
                errors++;
                $display("FAIL nomask_bus: addr/data=%h expected %h", {BUS_ADDR, BUS_DATA}, wexp);
            end
        end
        @(negedge CLK);
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_irq();
        test_blank_window();
        test_take_with_write();
        test_reset_abort();
        test_mask();
        checks++;
        if (rd_exp_q.size() != 0 || wr_exp_q.size() != 0 || ack_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: rd=%0d wr=%0d ack=%0d left expected 0/0/0",
                     rd_exp_q.size(), wr_exp_q.size(), ack_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
